decode_stage: RTL and testbench

Parametrised, pipelined instruction-decode stage for the 16-bit RISC core. It holds an 8-entry register file with a writeback port and same-cycle write-to-read bypass, and decodes opcode control signals and the sign-extended immediate. Results are registered into an ID/EX pipeline register with valid/ready handshakes on both sides. The stage detects load-use hazards against the instruction in its own output register, inserts one bubble when one occurs, and supports a flush from branch resolution.

---
 rtl/decode_stage_if.sv | 46 ++++
 rtl/decode_stage.sv | 187 ++++++++++++++++++
 tb/tb_decode_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Bundle of the decode stage's fetch-side handshake, writeback port, flush
// input and ID/EX output register. slave is the stage; master is its environment.
interface decode_stage_if #(
  parameter int DATA_W = 16
);
  // Fetch side
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  // Writeback port
  logic              wb_en;
  logic [2:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  // Branch-resolution flush
  logic              flush;
  // ID/EX side
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rs_data;
  logic [DATA_W-1:0] out_rt_data;
  logic [DATA_W-1:0] out_imm;
  logic [2:0]        out_rt;
  logic [2:0]        out_rd;
  logic [2:0]        out_wreg;
  logic              out_reg_write;
  logic              out_alu_src;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_mem_to_reg;
  logic              out_branch;
  logic [1:0]        out_alu_op;

  modport slave (
    input  in_valid, in_instr, wb_en, wb_addr, wb_data, flush, out_ready,
    output in_ready, out_valid, out_rs_data, out_rt_data, out_imm,
           out_rt, out_rd, out_wreg, out_reg_write, out_alu_src,
           out_mem_read, out_mem_write, out_mem_to_reg, out_branch, out_alu_op
  );

  modport master (
    output in_valid, in_instr, wb_en, wb_addr, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_rs_data, out_rt_data, out_imm,
           out_rt, out_rd, out_wreg, out_reg_write, out_alu_src,
           out_mem_read, out_mem_write, out_mem_to_reg, out_branch, out_alu_op
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction-decode stage of the 16-bit RISC core: 8-entry register file
// with write-to-read bypass, opcode/immediate decode, load-use bubble
// insertion, flush support and a valid/ready ID/EX pipeline register.
module decode_stage #(
  parameter int DATA_W   = 16,
  parameter bit ZERO_REG = 1'b1
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);

  typedef enum logic [2:0] {
    OP_RTYPE = 3'b000,
    OP_ADDI  = 3'b001,
    OP_LW    = 3'b010,
    OP_SW    = 3'b011,
    OP_BEQ   = 3'b100
  } opcode_e;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Instruction fields
  logic [2:0] opcode, rs, rt, rd;
  logic [6:0] imm7;
  assign opcode = bus.in_instr[15:13];
  assign rs     = bus.in_instr[12:10];
  assign rt     = bus.in_instr[9:7];
  assign rd     = bus.in_instr[6:4];
  assign imm7   = bus.in_instr[6:0];

  // Decoded values for the instruction on in_instr
  ctrl_t             dec_ctrl;
  logic [2:0]        dec_wreg;
  logic              uses_rs, uses_rt;
  logic [DATA_W-1:0] dec_imm;
  logic [DATA_W-1:0] rs_data, rt_data;

  // ID/EX register
  ctrl_t             q_ctrl;
  logic              q_valid;
  logic [DATA_W-1:0] q_rs_data, q_rt_data, q_imm;
  logic [2:0]        q_rt, q_rd, q_wreg;

  logic [DATA_W-1:0] regs [8];

  logic adv, hazard, accept, wreg_nonzero;

  assign dec_imm = {{(DATA_W-7){imm7[6]}}, imm7};

  // Opcode decode into control signals, destination and source usage
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
    dec_ctrl = CTRL_NONE;
    dec_wreg = 3'd0;
    uses_rs  = 1'b0;
    uses_rt  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = 2'b10;
        dec_wreg           = rd;
        uses_rs            = 1'b1;
        uses_rt            = 1'b1;
      end
      OP_ADDI: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_wreg           = rt;
        uses_rs            = 1'b1;
      end
      OP_LW: begin
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_wreg            = rt;
        uses_rs             = 1'b1;
      end
      OP_SW: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        uses_rs            = 1'b1;
        uses_rt            = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = 2'b01;
        uses_rs         = 1'b1;
        uses_rt         = 1'b1;
      end
      default: ;
    endcase
  end

  // Combinational register reads with same-cycle writeback bypass
  function automatic logic [DATA_W-1:0] read_reg(input logic [2:0] addr);
    if (ZERO_REG && addr == 3'd0)
      return '0;
    else if (bus.wb_en && bus.wb_addr == addr)
      return bus.wb_data;
    else
      return regs[addr];
  endfunction

  assign rs_data = read_reg(rs);
  assign rt_data = read_reg(rt);

  // Load-use hazard against the load sitting in the ID/EX register
  assign wreg_nonzero = ZERO_REG ? (q_wreg != 3'd0) : 1'b1;
  assign hazard = bus.in_valid && q_valid && q_ctrl.mem_read && wreg_nonzero &&
                  ((uses_rs && q_wreg == rs) || (uses_rt && q_wreg == rt));
  assign adv    = !q_valid || bus.out_ready;
  assign accept = bus.in_valid && !hazard;

  assign bus.in_ready = adv && !hazard && !reset;

  // Register file writes, independent of stall and flush
  always_ff @(posedge clk) begin
    // NOTE: the register file is cleared on reset because a reset mid-stream must leave all registers at zero.
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (bus.wb_en && !(ZERO_REG && bus.wb_addr == 3'd0)) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // ID/EX register: load, bubble, flush or hold
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      q_valid   <= 1'b0;
      q_ctrl    <= CTRL_NONE;
      q_rs_data <= '0;
      q_rt_data <= '0;
      q_imm     <= '0;
      q_rt      <= '0;
      q_rd      <= '0;
      q_wreg    <= '0;
    end else if (adv) begin
      if (bus.flush) begin
        q_valid <= 1'b0;
        q_ctrl  <= CTRL_NONE;
      end else if (accept) begin
        q_valid   <= 1'b1;
        q_ctrl    <= dec_ctrl;
        q_rs_data <= rs_data;
        q_rt_data <= rt_data;
        q_imm     <= dec_imm;
        q_rt      <= rt;
        q_rd      <= rd;
        q_wreg    <= dec_wreg;
      end else begin
        q_valid <= 1'b0;
        q_ctrl  <= CTRL_NONE;
      end
    end else if (bus.flush) begin
      q_valid <= 1'b0;
    end
  end

  assign bus.out_valid      = q_valid;
  assign bus.out_rs_data    = q_rs_data;
  assign bus.out_rt_data    = q_rt_data;
  assign bus.out_imm        = q_imm;
  assign bus.out_rt         = q_rt;
  assign bus.out_rd         = q_rd;
  assign bus.out_wreg       = q_wreg;
  assign bus.out_reg_write  = q_ctrl.reg_write;
  assign bus.out_alu_src    = q_ctrl.alu_src;
  assign bus.out_mem_read   = q_ctrl.mem_read;
  assign bus.out_mem_write  = q_ctrl.mem_write;
  assign bus.out_mem_to_reg = q_ctrl.mem_to_reg;
  assign bus.out_branch     = q_ctrl.branch;
  assign bus.out_alu_op     = q_ctrl.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 16-bit instance exercises decode,
// bypass, load-use bubble, stall, flush and reset; a 32-bit instance checks
// immediate sign extension and the NOP opcode.
module tb_decode_stage;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.DATA_W(16)) bus_a ();
  decode_stage_if #(.DATA_W(32)) bus_b ();

  decode_stage #(.DATA_W(16), .ZERO_REG(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  decode_stage #(.DATA_W(32), .ZERO_REG(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are sampled 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational in_ready settle after input changes
  task automatic settle();
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [15:0] instr);
    bus_a.in_valid = v;
    bus_a.in_instr = instr;
  endtask

  task automatic wb_a(input logic en, input logic [2:0] addr, input logic [15:0] data);
    bus_a.wb_en   = en;
    bus_a.wb_addr = addr;
    bus_a.wb_data = data;
  endtask

  initial begin
    reset = 1'b1;
    drive_a(1'b0, 16'h0000);
    wb_a(1'b0, 3'd0, 16'h0000);
    bus_a.flush     = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid  = 1'b0;
    bus_b.in_instr  = 16'h0000;
    bus_b.wb_en     = 1'b0;
    bus_b.wb_addr   = 3'd0;
    bus_b.wb_data   = 32'h0;
    bus_b.flush     = 1'b0;
    bus_b.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    drive_a(1'b1, 16'h20FF);
    settle();
    chk("rst_in_ready", 32'(bus_a.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_reg_write", 32'(bus_a.out_reg_write), 32'd0);
    chk("rst_imm", 32'(bus_a.out_imm), 32'd0);
    tick();
    chk("rst_hold_valid", 32'(bus_a.out_valid), 32'd0);

    // ADDI r1, r0, -1 (0x20FF)
    reset = 1'b0;
    settle();
    chk("addi_in_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    chk("addi_valid", 32'(bus_a.out_valid), 32'd1);
    chk("addi_imm", 32'(bus_a.out_imm), 32'h0000FFFF);
    chk("addi_wreg", 32'(bus_a.out_wreg), 32'd1);
    chk("addi_reg_write", 32'(bus_a.out_reg_write), 32'd1);
    chk("addi_alu_src", 32'(bus_a.out_alu_src), 32'd1);
    chk("addi_alu_op", 32'(bus_a.out_alu_op), 32'd0);
    chk("addi_mem_read", 32'(bus_a.out_mem_read), 32'd0);

    // R-type rs=r3 rt=r0 rd=r4 with same-cycle writeback r3 <= 0x1234
    drive_a(1'b1, 16'h0C40);
    wb_a(1'b1, 3'd3, 16'h1234);
    tick();
    chk("byp_rs_data", 32'(bus_a.out_rs_data), 32'h1234);
    chk("byp_rt_data", 32'(bus_a.out_rt_data), 32'h0);
    chk("rtype_wreg", 32'(bus_a.out_wreg), 32'd4);
    chk("rtype_alu_op", 32'(bus_a.out_alu_op), 32'd2);
    chk("rtype_alu_src", 32'(bus_a.out_alu_src), 32'd0);

    // R-type rs=r0 rt=r3 rd=r5 while writing r0 <= 0xBEEF (ignored)
    drive_a(1'b1, 16'h01D0);
    wb_a(1'b1, 3'd0, 16'hBEEF);
    tick();
    chk("r0_bypass_zero", 32'(bus_a.out_rs_data), 32'h0);
    chk("r3_from_file", 32'(bus_a.out_rt_data), 32'h1234);

    // r0 after the ignored write still reads zero: R-type rs=r0 rt=r0 rd=r1
    drive_a(1'b1, 16'h0010);
    wb_a(1'b0, 3'd0, 16'h0000);
    tick();
    chk("r0_file_zero", 32'(bus_a.out_rs_data), 32'h0);

    // LW r2, 2(r3) while writing r2 <= 0x0055
    drive_a(1'b1, 16'h4D02);
    wb_a(1'b1, 3'd2, 16'h0055);
    tick();
    chk("lw_valid", 32'(bus_a.out_valid), 32'd1);
    chk("lw_mem_read", 32'(bus_a.out_mem_read), 32'd1);
    chk("lw_mem_to_reg", 32'(bus_a.out_mem_to_reg), 32'd1);
    chk("lw_wreg", 32'(bus_a.out_wreg), 32'd2);
    chk("lw_rs_data", 32'(bus_a.out_rs_data), 32'h1234);
    chk("lw_imm", 32'(bus_a.out_imm), 32'h0002);

    // Dependent R-type rs=r2 rt=r1 rd=r6: one stall, one bubble, then issue
    wb_a(1'b0, 3'd0, 16'h0000);
    drive_a(1'b1, 16'h08E0);
    settle();
    chk("hz_in_ready", 32'(bus_a.in_ready), 32'd0);
    tick();
    chk("hz_bubble_valid", 32'(bus_a.out_valid), 32'd0);
    chk("hz_bubble_mem_read", 32'(bus_a.out_mem_read), 32'd0);
    chk("hz_bubble_reg_write", 32'(bus_a.out_reg_write), 32'd0);
    chk("hz_clear_in_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    chk("hz_issue_valid", 32'(bus_a.out_valid), 32'd1);
    chk("hz_issue_wreg", 32'(bus_a.out_wreg), 32'd6);
    chk("hz_issue_rs_data", 32'(bus_a.out_rs_data), 32'h0055);

    // LW r2 then ADDI r2, r1, 3 (r2 only as destination): no stall
    drive_a(1'b1, 16'h4D02);
    tick();
    drive_a(1'b1, 16'h2503);
    settle();
    chk("nohz_in_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    chk("nohz_valid", 32'(bus_a.out_valid), 32'd1);
    chk("nohz_imm", 32'(bus_a.out_imm), 32'h0003);
    chk("nohz_mem_read", 32'(bus_a.out_mem_read), 32'd0);

    // Back-pressure for 3 cycles with BEQ r1, r2, 5 waiting
    drive_a(1'b1, 16'h8505);
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_in_ready", 32'(bus_a.in_ready), 32'd0);
      tick();
      chk("stall_valid", 32'(bus_a.out_valid), 32'd1);
      chk("stall_imm", 32'(bus_a.out_imm), 32'h0003);
      chk("stall_branch", 32'(bus_a.out_branch), 32'd0);
    end
    bus_a.out_ready = 1'b1;
    settle();
    chk("release_in_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    chk("beq_valid", 32'(bus_a.out_valid), 32'd1);
    chk("beq_branch", 32'(bus_a.out_branch), 32'd1);
    chk("beq_alu_op", 32'(bus_a.out_alu_op), 32'd1);
    chk("beq_imm", 32'(bus_a.out_imm), 32'h0005);
    chk("beq_reg_write", 32'(bus_a.out_reg_write), 32'd0);
    drive_a(1'b0, 16'h0000);
    tick();
    chk("no_dup_valid", 32'(bus_a.out_valid), 32'd0);

    // Flush with a valid output and SW r2, 7(r1) being presented
    drive_a(1'b1, 16'h20FF);
    tick();
    chk("pre_flush_valid", 32'(bus_a.out_valid), 32'd1);
    drive_a(1'b1, 16'h6507);
    bus_a.flush = 1'b1;
    tick();
    chk("flush_valid", 32'(bus_a.out_valid), 32'd0);
    chk("flush_mem_write", 32'(bus_a.out_mem_write), 32'd0);
    bus_a.flush = 1'b0;
    drive_a(1'b0, 16'h0000);
    tick();
    chk("flushed_gone_valid", 32'(bus_a.out_valid), 32'd0);
    chk("flushed_gone_mem_write", 32'(bus_a.out_mem_write), 32'd0);

    // Hazard pending while EX is stalled: hold with in_ready low
    drive_a(1'b1, 16'h4D02);
    tick();
    bus_a.out_ready = 1'b0;
    drive_a(1'b1, 16'h08E0);
    settle();
    chk("hz_stall_in_ready", 32'(bus_a.in_ready), 32'd0);
    tick();
    chk("hz_stall_hold_lw", 32'(bus_a.out_mem_read), 32'd1);
    bus_a.out_ready = 1'b1;
    drive_a(1'b0, 16'h0000);
    tick();

    // Reset mid-stream clears the register file (r3 was 0x1234)
    drive_a(1'b1, 16'h0C40);
    tick();
    chk("pre_rst_valid", 32'(bus_a.out_valid), 32'd1);
    reset = 1'b1;
    settle();
    chk("mid_rst_in_ready", 32'(bus_a.in_ready), 32'd0);
    tick();
    chk("mid_rst_valid", 32'(bus_a.out_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_r3", 32'(bus_a.out_rs_data), 32'h0);
    chk("post_rst_valid", 32'(bus_a.out_valid), 32'd1);
    drive_a(1'b0, 16'h0000);

    // 32-bit instance: ADDI r1, r0, imm=0x40 then opcode 111
    bus_b.in_valid = 1'b1;
    bus_b.in_instr = 16'h20C0;
    tick();
    chk("w32_imm", bus_b.out_imm, 32'hFFFFFFC0);
    chk("w32_valid", 32'(bus_b.out_valid), 32'd1);
    bus_b.in_instr = 16'hE000;
    tick();
    chk("nop_valid", 32'(bus_b.out_valid), 32'd1);
    chk("nop_ctrl", {24'd0, bus_b.out_reg_write, bus_b.out_alu_src, bus_b.out_mem_read,
                     bus_b.out_mem_write, bus_b.out_mem_to_reg, bus_b.out_branch,
                     bus_b.out_alu_op}, 32'd0);
    chk("nop_wreg", 32'(bus_b.out_wreg), 32'd0);
    bus_b.in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
